lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Consumes the main decoder's data-memory controls (memWrite, load select, DQM size code, funct3) together with the ALU address and store data.
- Runs one request/acknowledge transaction per load or store on the external data bus.
- Performs byte-lane steering, byte enables, load sign/zero extension and misalignment detection.
- Holds the pipeline with a stall signal until the access completes.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 255, max ACCESS cycles without ack/err before fault (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_write  in  1  decoder memWrite: store request
mem_read  in  1  load request (decoder resultSrc==01)
dqm  in  2  size: 00 byte, 01 half, 10 word; 11 treated as byte
funct3  in  3  instruction funct3; bit2=1 means unsigned load
addr  in  ADDR_W  byte address from ALU
wdata  in  32  store data (rs2)
stall  out  1  hold pipeline
rdata  out  32  extended load result, valid while done=1
done  out  1  one-cycle completion pulse
fault  out  1  with done: misaligned, bus error or timeout
bus_req  out  1  transaction request
bus_we  out  1  1 write, 0 read
bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-steered store data
bus_ack  in  1  slave completion; read data valid same cycle
bus_err  in  1  slave error completion
bus_rdata  in  32  read data

Behaviour:
- Reset: state IDLE; stall, done, fault, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata, timeout counter = 0. Asynchronous: bus_req drops immediately, any in-flight access is abandoned, no done.
- FSM states:
  - IDLE, ACCESS, DONE.
- IDLE:
  - req = mem_write | mem_read. If both are set, write wins.
  - stall = req, combinational.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) -> DONE with fault=1. No bus cycle is issued.
  - Aligned request -> ACCESS. At that edge register bus_addr={addr[ADDR_W-1:2],2'b00}, bus_we, bus_be, bus_wdata, the offset addr[1:0], the size, and funct3[2]. Clear the counter.
- Byte enables:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<off.
  - word: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- ACCESS:
  - bus_req=1, stall=1, counter increments each cycle.
  - bus_ack -> DONE and capture extended rdata.
  - bus_err -> DONE with fault=1. If ack and err are both set, err wins.
  - counter==TIMEOUT_CYCLES-1 with neither -> DONE with fault=1. bus_req drops.
  - Request inputs are ignored in this state.
- DONE:
  - done=1, stall=0, bus_req=0; pipeline retires the instruction at the end of this cycle. Next state IDLE.
  - rdata is only updated on successful loads and is held otherwise. For stores, rdata is don't-care.
  - fault clears on leaving DONE.
- Load extension: lane = bus_rdata >> (8*off).
  - Byte: sign-extend bit7, or zero-extend if funct3[2].
  - Half: sign-extend bit15, or zero-extend.
  - Word: pass through.
- Timing:
  - Minimum aligned latency is 3 cycles: request cycle, ACCESS with ack, DONE.
  - Misaligned access takes 2 cycles.
  - Back-to-back requests: the next instruction is seen in IDLE the cycle after DONE; no bubble beyond that.

Decomposition:
- Package lsu_pkg: DQM codes (BYTE/HALF/WORD), FSM state enum, load funct3 codes (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension (bus_rdata, off, size, unsigned -> rdata). Also unit-testable alone.

Test Plan:
- SB: addr=0x1003, wdata=0x000000A5, ack after 2 cycles -> bus_addr=0x1000, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1, stall high 4 cycles, done pulse, fault=0.
- LB/LBU: addr=0x2001, bus_rdata=0x123480FF, zero-wait ack -> bus_be=0010; LB rdata=0xFFFFFF80, LBU rdata=0x00000080; done on 3rd cycle.
- LH: addr=0x3001 -> no bus_req ever, done+fault on 2nd cycle, stall high 1 cycle only. LW at 0x3002 gives the same result.
- Load with bus_err=1 and bus_ack=1 in the same cycle -> done with fault=1, rdata unchanged. Load with no response and TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, then done+fault.
- Assert rst_n low mid-ACCESS -> bus_req and stall drop asynchronously, no done. After release, SW at 0x10 with 0xDEADBEEF -> bus_be=1111, bus_wdata=0xDEADBEEF.
- Back-to-back SH 0x0102 (wdata 0xBEEF) then LHU 0x0102 (rdata 0xBEEF0000) -> be 1100 / wdata 0xBEEFBEEF, then rdata=0x0000BEEF; second bus_req starts 2 cycles after first done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states,
// load funct3 encodings and the request decode helpers used at issue time.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // The unused dqm code 11 behaves as a byte access.
    function automatic size_t norm_size(input logic [1:0] dqm);
        return (dqm == 2'b11) ? SZ_BYTE : size_t'(dqm);
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(input size_t size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b0001 << off;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input size_t size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_WORD: d = wdata;
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = {4{wdata[7:0]}};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Purpose: select the addressed lane of a bus read word and sign/zero extend it.
// Latency: purely combinational.
// Backpressure: none; the result is meaningful only in the cycle the bus acks.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] lane;

    always_comb begin
        lane  = bus_rdata >> {off, 3'b000};
        rdata = lane;
        case (size)
            SZ_WORD: rdata = lane;
            SZ_HALF: rdata = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            default: rdata = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Purpose: run one req/ack data-bus transaction per load or store from the decoder.
// Latency: 3 cycles minimum when aligned (issue, ACCESS with ack, DONE); 2 when misaligned.
// Backpressure: stall holds the pipeline from the issue cycle until the DONE cycle.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        dqm,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              fault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    size_t              size_q;
    logic               uns_q;
    logic               req;
    size_t              size_in;
    logic [31:0]        ld_data;
    logic               unused_f3;

    assign req       = mem_write | mem_read;
    assign size_in   = norm_size(dqm);
    assign unused_f3 = ^funct3[1:0];

    // Gated by rst_n so the pipeline is released the moment reset is asserted.
    assign stall = rst_n & (((state == ST_IDLE) & req) | (state == ST_ACCESS));

    lsu_load_align u_align (
        .bus_rdata   (bus_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            off_q     <= 2'b00;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (is_misaligned(size_in, addr[1:0])) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= lane_be(size_in, addr[1:0]);
                            bus_wdata <= lane_wdata(size_in, wdata);
                            off_q     <= addr[1:0];
                            size_q    <= size_in;
                            uns_q     <= funct3[2];
                            cnt       <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (bus_err) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end else if (bus_ack) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        if (!bus_we) rdata <= ld_data;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master with a bus slave driven from the bench.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0, mem_read = 1'b0;
    logic [1:0]  dqm = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        chk_rdata;
    } exp_t;

    exp_t sbq[$];
    exp_t ex;
    int total = 0, bad = 0;
    int cyc = 0;
    int n_stall, n_req, n_cyc, t_req, t_done;
    bit seen;
    logic [31:0] o_rdata, cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        o_fault, cap_we;

    lsu_bus_master #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
        .dqm(dqm), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic issue(input logic w, input logic r, input logic [1:0] d, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ef, input logic ec);
        exp_t e;
        mem_write = w; mem_read = r; dqm = d; funct3 = f; addr = a; wdata = wd;
        e.rdata = er; e.fault = ef; e.chk_rdata = ec;
        sbq.push_back(e);
    endtask

    // Acts as the bus slave: responds on the ack_at-th ACCESS cycle (0 = never).
    task automatic service(input int ack_at, input bit use_err);
        n_stall = 0; n_req = 0; n_cyc = 0; seen = 0; o_rdata = '0; o_fault = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            #1;
            n_cyc = c + 1;
            if (stall) n_stall++;
            if (done) begin seen = 1; o_rdata = rdata; o_fault = fault; t_done = cyc; end
            if (bus_req) begin
                n_req++;
                if (n_req == 1) begin
                    t_req = cyc; cap_addr = bus_addr; cap_be = bus_be;
                    cap_wdata = bus_wdata; cap_we = bus_we;
                end
            end
            bus_ack = bus_req && (ack_at != 0) && (n_req == ack_at);
            bus_err = bus_ack && use_err;
            @(negedge clk);
            mem_write = 1'b0; mem_read = 1'b0;
        end
        bus_ack = 1'b0; bus_err = 1'b0;
    endtask

    task automatic check_sb(input string name);
        ex = sbq.pop_front();
        total++;
        if (!seen) begin bad++; $display("FAIL %s_done: no done within budget", name); end
        total++;
        if (o_fault !== ex.fault) begin bad++; $display("FAIL %s_fault: got %b want %b", name, o_fault, ex.fault); end
        if (ex.chk_rdata) begin
            total++;
            if (o_rdata !== ex.rdata) begin bad++; $display("FAIL %s_rdata: got %h want %h", name, o_rdata, ex.rdata); end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if ({stall, done, fault, bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %b/%b/%b/%b/%b %h %b %h %h want all zero",
                stall, done, fault, bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sb();
        issue(1, 0, 2'b00, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
        service(3, 0);
        check_sb("sb");
        total++; if (cap_addr !== 32'h1000) begin bad++; $display("FAIL sb_addr: got %h want 00001000", cap_addr); end
        total++; if (cap_be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", cap_be); end
        total++; if (cap_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", cap_wdata); end
        total++; if (cap_we !== 1'b1) begin bad++; $display("FAIL sb_we: got %b want 1", cap_we); end
        total++; if (n_stall != 4) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 4", n_stall); end
    endtask

    task automatic test_byte_loads();
        bus_rdata = 32'h1234_80FF;
        issue(0, 1, 2'b00, 3'b000, 32'h2001, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
        service(1, 0);
        check_sb("lb");
        total++; if (cap_be !== 4'b0010) begin bad++; $display("FAIL lb_be: got %b want 0010", cap_be); end
        total++; if (cap_we !== 1'b0) begin bad++; $display("FAIL lb_we: got %b want 0", cap_we); end
        total++; if (n_cyc != 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", n_cyc); end
        issue(0, 1, 2'b00, 3'b100, 32'h2001, 32'h0, 32'h0000_0080, 1'b0, 1'b1);
        service(1, 0);
        check_sb("lbu");
    endtask

    task automatic test_misaligned();
        issue(0, 1, 2'b01, 3'b001, 32'h3001, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        service(0, 0);
        check_sb("lh_mis");
        total++; if (n_req != 0) begin bad++; $display("FAIL lh_mis_req: got %0d want 0", n_req); end
        total++; if (n_cyc != 2) begin bad++; $display("FAIL lh_mis_latency: got %0d want 2", n_cyc); end
        total++; if (n_stall != 1) begin bad++; $display("FAIL lh_mis_stall: got %0d want 1", n_stall); end
        issue(0, 1, 2'b10, 3'b010, 32'h3002, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        service(0, 0);
        check_sb("lw_mis");
        total++; if (n_req != 0) begin bad++; $display("FAIL lw_mis_req: got %0d want 0", n_req); end
        total++; if (n_cyc != 2) begin bad++; $display("FAIL lw_mis_latency: got %0d want 2", n_cyc); end
    endtask

    task automatic test_err_timeout();
        bus_rdata = 32'hCAFE_F00D;
        issue(0, 1, 2'b10, 3'b010, 32'h4000, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        service(1, 1);
        check_sb("err");
        issue(0, 1, 2'b10, 3'b010, 32'h5000, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        service(0, 0);
        check_sb("timeout");
        total++; if (n_req != 4) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 4", n_req); end
        total++; if (n_cyc != 6) begin bad++; $display("FAIL timeout_latency: got %0d want 6", n_cyc); end
    endtask

    task automatic test_async_reset();
        int dcount;
        mem_read = 1'b1; dqm = 2'b10; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk); #1;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL arst_pre_req: got %b want 1", bus_req); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL arst_req: got %b want 0", bus_req); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL arst_stall: got %b want 0", stall); end
        mem_read = 1'b0;
        dcount = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (done) dcount++; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (done) dcount++; end
        total++; if (dcount != 0) begin bad++; $display("FAIL arst_no_done: got %0d want 0", dcount); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_rdata: got %h want 00000000", rdata); end
        @(negedge clk);
        issue(1, 0, 2'b10, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        service(1, 0);
        check_sb("sw");
        total++; if (cap_be !== 4'b1111) begin bad++; $display("FAIL sw_be: got %b want 1111", cap_be); end
        total++; if (cap_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", cap_wdata); end
        total++; if (cap_addr !== 32'h10) begin bad++; $display("FAIL sw_addr: got %h want 00000010", cap_addr); end
    endtask

    task automatic test_back_to_back();
        int first_done;
        bus_rdata = 32'hBEEF_0000;
        issue(1, 0, 2'b01, 3'b001, 32'h0102, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0);
        service(1, 0);
        check_sb("sh");
        first_done = t_done;
        total++; if (cap_be !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", cap_be); end
        total++; if (cap_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata: got %h want beefbeef", cap_wdata); end
        issue(0, 1, 2'b01, 3'b101, 32'h0102, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
        service(1, 0);
        check_sb("lhu");
        total++; if (t_req - first_done != 2) begin bad++; $display("FAIL b2b_gap: got %0d want 2", t_req - first_done); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_byte_loads();
        test_misaligned();
        test_err_timeout();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
